// File: rtl/sram_rd_arb.sv
// Two-client round-robin read arbiter for a single-port SRAM.
// Query and target parsers share one read port; returns are routed by tag.
module sram_rd_arb #(
  parameter int WORD_W = 30,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1,
  parameter int T_BASE = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              q_req_i,
  input  logic [ADDR_W-1:0] q_addr_i,
  output logic [WORD_W-1:0] q_data_o,
  output logic              q_valid_o,
  input  logic              t_req_i,
  input  logic [ADDR_W-1:0] t_addr_i,
  output logic [WORD_W-1:0] t_data_o,
  output logic              t_valid_o,
  output logic              sram_cen_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  input  logic [WORD_W-1:0] sram_q_i
);

  localparam logic [ADDR_W-1:0] T_OFF = ADDR_W'(T_BASE);

  logic              q_out;
  logic              t_out;
  logic              last_t;
  logic              q_elig;
  logic              t_elig;
  logic              gnt_q;
  logic              gnt_t;
  logic              gnt;
  logic [ADDR_W-1:0] issue_addr;
  logic [RD_LAT:0]   tag_v;
  logic [RD_LAT:0]   tag_t;
  logic              ret_q;
  logic              ret_t;

  assign q_elig = q_req_i & ~q_out;
  assign t_elig = t_req_i & ~t_out;

  always_comb begin
    gnt_q = 1'b0;
    gnt_t = 1'b0;
    if (q_elig && t_elig) begin
      gnt_q = last_t;
      gnt_t = ~last_t;
    end else begin
      gnt_q = q_elig;
      gnt_t = t_elig;
    end
  end

  assign gnt        = gnt_q | gnt_t;
  assign issue_addr = gnt_t ? (t_addr_i + T_OFF) : q_addr_i;

  // Tag slot RD_LAT lines up with the cycle the SRAM data is on sram_q_i.
  assign ret_q = tag_v[RD_LAT] & ~tag_t[RD_LAT];
  assign ret_t = tag_v[RD_LAT] & tag_t[RD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_cen_o  <= 1'b1;
      sram_addr_o <= '0;
      tag_v       <= '0;
      tag_t       <= '0;
      q_valid_o   <= 1'b0;
      t_valid_o   <= 1'b0;
      q_data_o    <= '0;
      t_data_o    <= '0;
      q_out       <= 1'b0;
      t_out       <= 1'b0;
      last_t      <= 1'b1;
    end else begin
      sram_cen_o <= ~gnt;
      if (gnt) begin
        sram_addr_o <= issue_addr;
      end
      tag_v     <= {tag_v[RD_LAT-1:0], gnt};
      tag_t     <= {tag_t[RD_LAT-1:0], gnt_t};
      q_valid_o <= ret_q;
      t_valid_o <= ret_t;
      if (ret_q) begin
        q_data_o <= sram_q_i;
      end
      if (ret_t) begin
        t_data_o <= sram_q_i;
      end
      // Busy from grant through the valid_o cycle inclusive.
      if (gnt_q) begin
        q_out <= 1'b1;
      end else if (q_valid_o) begin
        q_out <= 1'b0;
      end
      if (gnt_t) begin
        t_out <= 1'b1;
      end else if (t_valid_o) begin
        t_out <= 1'b0;
      end
      if (gnt_q) begin
        last_t <= 1'b0;
      end else if (gnt_t) begin
        last_t <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sram_rd_arb.sv
// Bench for sram_rd_arb: instance 0 uses RD_LAT=1, instance 1 RD_LAT=3.
// A cycle-level scoreboard predicts every output of both instances.
module tb_sram_rd_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        q_req [2];
  logic        t_req [2];
  logic [9:0]  q_addr [2];
  logic [9:0]  t_addr [2];
  logic [29:0] q_data [2];
  logic [29:0] t_data [2];
  logic        q_valid [2];
  logic        t_valid [2];
  logic        sram_cen [2];
  logic [9:0]  sram_addr [2];
  logic [29:0] sq0;
  logic [29:0] sq1;
  logic [29:0] s1;
  logic [29:0] s2;
  logic [29:0] mem [0:1023];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int          busy_q [2];
  int          busy_t [2];
  bit          last_t [2];
  bit          r_cen [2][16];
  bit          r_qv [2][16];
  bit          r_tv [2][16];
  logic [9:0]  r_addr [2][16];
  logic [29:0] r_dat [2][16];
  logic        e_cen [2];
  logic [9:0]  e_addr [2];
  logic        e_qv [2];
  logic        e_tv [2];
  logic [29:0] e_qd [2];
  logic [29:0] e_td [2];

  localparam logic [72:0] RST_V = {1'b1, 72'd0};

  always #5 clk = ~clk;

  // SRAM models: latency 1 and latency 3
  always @(posedge clk) begin
    sq0 <= mem[sram_addr[0]];
    s1  <= mem[sram_addr[1]];
    s2  <= s1;
    sq1 <= s2;
  end

  sram_rd_arb u0 (
    .clk(clk), .rst_n(rst_n),
    .q_req_i(q_req[0]), .q_addr_i(q_addr[0]),
    .q_data_o(q_data[0]), .q_valid_o(q_valid[0]),
    .t_req_i(t_req[0]), .t_addr_i(t_addr[0]),
    .t_data_o(t_data[0]), .t_valid_o(t_valid[0]),
    .sram_cen_o(sram_cen[0]), .sram_addr_o(sram_addr[0]),
    .sram_q_i(sq0)
  );

  sram_rd_arb #(.RD_LAT(3)) u1 (
    .clk(clk), .rst_n(rst_n),
    .q_req_i(q_req[1]), .q_addr_i(q_addr[1]),
    .q_data_o(q_data[1]), .q_valid_o(q_valid[1]),
    .t_req_i(t_req[1]), .t_addr_i(t_addr[1]),
    .t_data_o(t_data[1]), .t_valid_o(t_valid[1]),
    .sram_cen_o(sram_cen[1]), .sram_addr_o(sram_addr[1]),
    .sram_q_i(sq1)
  );

  function automatic logic [72:0] obs(int k);
    return {sram_cen[k], sram_addr[k], q_valid[k], t_valid[k],
            q_data[k], t_data[k]};
  endfunction

  function automatic logic [72:0] expv(int k);
    return {e_cen[k], e_addr[k], e_qv[k], e_tv[k], e_qd[k], e_td[k]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      busy_q[k] = -1;
      busy_t[k] = -1;
      last_t[k] = 1'b1;
      e_cen[k]  = 1'b1;
      e_addr[k] = '0;
      e_qv[k]   = 1'b0;
      e_tv[k]   = 1'b0;
      e_qd[k]   = '0;
      e_td[k]   = '0;
      for (int s = 0; s < 16; s++) begin
        r_cen[k][s] = 1'b0;
        r_qv[k][s]  = 1'b0;
        r_tv[k][s]  = 1'b0;
      end
    end
  endtask

  // Decide the grant for the cycle just ended and schedule its effects.
  task automatic model_step(int k);
    int c;
    int g;
    int a;
    int lat;
    int d;
    bit qe;
    bit te;
    c = cyc;
    g = -1;
    a = 0;
    lat = (k == 0) ? 1 : 3;
    qe = q_req[k] && (c > busy_q[k]);
    te = t_req[k] && (c > busy_t[k]);
    if (qe && te) g = last_t[k] ? 0 : 1;
    else if (qe) g = 0;
    else if (te) g = 1;
    if (g >= 0) begin
      if (g == 0) a = int'(q_addr[k]);
      else a = (int'(t_addr[k]) + 512) % 1024;
      r_cen[k][(c + 1) % 16]  = 1'b1;
      r_addr[k][(c + 1) % 16] = 10'(a);
      d = (c + lat + 2) % 16;
      if (g == 0) begin
        r_qv[k][d] = 1'b1;
        busy_q[k] = c + lat + 2;
      end else begin
        r_tv[k][d] = 1'b1;
        busy_t[k] = c + lat + 2;
      end
      r_dat[k][d] = mem[a];
      last_t[k] = (g == 1);
    end
  endtask

  task automatic model_apply(int k);
    int s;
    s = cyc % 16;
    e_cen[k] = !r_cen[k][s];
    if (r_cen[k][s]) e_addr[k] = r_addr[k][s];
    e_qv[k] = r_qv[k][s];
    e_tv[k] = r_tv[k][s];
    if (r_qv[k][s]) e_qd[k] = r_dat[k][s];
    if (r_tv[k][s]) e_td[k] = r_dat[k][s];
    r_cen[k][s] = 1'b0;
    r_qv[k][s]  = 1'b0;
    r_tv[k][s]  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      model_step(0);
      model_step(1);
      cyc++;
      model_apply(0);
      model_apply(1);
    end
    #1;
  endtask

  task automatic idle_inputs();
    for (int k = 0; k < 2; k++) begin
      q_req[k] = 1'b0;
      t_req[k] = 1'b0;
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    for (int k = 0; k < 2; k++) begin
      q_addr[k] = '0;
      t_addr[k] = '0;
    end
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs(k) !== RST_V) begin
        failures++;
        $display("FAIL reset k=%0d got=%h exp=%h", k, obs(k), RST_V);
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs(k) !== RST_V) begin
        failures++;
        $display("FAIL reset_hold k=%0d got=%h exp=%h", k, obs(k), RST_V);
      end
    end
  endtask

  task automatic test_single();
    mem[0] = 30'h2AAAAAAA;
    do_reset();
    q_addr[0] = 10'd0;
    q_req[0]  = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs(k) !== expv(k)) begin
          failures++;
          $display("FAIL single k=%0d i=%0d got=%h exp=%h",
                   k, i, obs(k), expv(k));
        end
      end
      if (i == 1) begin
        checks++;
        if ({sram_cen[0], sram_addr[0]} !== 11'd0) begin
          failures++;
          $display("FAIL single_issue got=%b/%0d exp=0/0",
                   sram_cen[0], sram_addr[0]);
        end
      end
      if (i == 2 || i == 3 || i == 4) begin
        checks++;
        if (sram_cen[0] !== 1'b1) begin
          failures++;
          $display("FAIL single_noreread i=%0d cen=%b exp=1", i, sram_cen[0]);
        end
      end
      if (i == 3) begin
        checks++;
        if ({q_valid[0], q_data[0]} !== {1'b1, 30'h2AAAAAAA}) begin
          failures++;
          $display("FAIL single_data got=%b/%h exp=1/2aaaaaaa",
                   q_valid[0], q_data[0]);
        end
      end
      tick();
      if (i == 5) q_req[0] = 1'b0;
    end
  endtask

  task automatic test_tie();
    do_reset();
    q_addr[0] = 10'd5;
    t_addr[0] = 10'd5;
    q_req[0]  = 1'b1;
    t_req[0]  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs(k) !== expv(k)) begin
          failures++;
          $display("FAIL tie k=%0d i=%0d got=%h exp=%h",
                   k, i, obs(k), expv(k));
        end
      end
      if (i == 1 || i == 2) begin
        checks++;
        if ({sram_cen[0], sram_addr[0]} !== {1'b0, (i == 1) ? 10'd5 : 10'd517})
        begin
          failures++;
          $display("FAIL tie_addr i=%0d got=%b/%0d", i,
                   sram_cen[0], sram_addr[0]);
        end
      end
      if (i == 3 || i == 4) begin
        checks++;
        if ({q_valid[0], t_valid[0]} !== ((i == 3) ? 2'b10 : 2'b01)) begin
          failures++;
          $display("FAIL tie_valid i=%0d got=%b%b", i, q_valid[0], t_valid[0]);
        end
      end
      tick();
      if (i == 4) begin
        q_req[0] = 1'b0;
        t_req[0] = 1'b0;
      end
      if (i == 8) begin
        q_req[0] = 1'b1;
        t_req[0] = 1'b1;
      end
    end
    idle_inputs();
  endtask

  task automatic test_wrap();
    do_reset();
    t_addr[0] = 10'd600;
    t_req[0]  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs(k) !== expv(k)) begin
          failures++;
          $display("FAIL wrap k=%0d i=%0d got=%h exp=%h",
                   k, i, obs(k), expv(k));
        end
      end
      if (i == 1) begin
        checks++;
        if ({sram_cen[0], sram_addr[0]} !== {1'b0, 10'd88}) begin
          failures++;
          $display("FAIL wrap_addr got=%b/%0d exp=0/88",
                   sram_cen[0], sram_addr[0]);
        end
      end
      tick();
      if (i == 3) t_req[0] = 1'b0;
    end
  endtask

  task automatic test_drop();
    do_reset();
    q_addr[0] = 10'($urandom_range(0, 1023));
    t_addr[0] = 10'($urandom_range(0, 1023));
    q_req[0]  = 1'b1;
    t_req[0]  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs(k) !== expv(k)) begin
          failures++;
          $display("FAIL drop k=%0d i=%0d got=%h exp=%h",
                   k, i, obs(k), expv(k));
        end
      end
      if (i == 3 || i == 4) begin
        checks++;
        if ({q_valid[0], t_valid[0]} !== ((i == 3) ? 2'b10 : 2'b01)) begin
          failures++;
          $display("FAIL drop_valid i=%0d got=%b%b", i, q_valid[0], t_valid[0]);
        end
      end
      tick();
      if (i == 0) q_req[0] = 1'b0;
      if (i == 4) t_req[0] = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    q_addr[0] = 10'd7;
    q_req[0]  = 1'b1;
    q_addr[1] = 10'd9;
    q_req[1]  = 1'b1;
    tick();
    rst_n = 1'b0;
    model_reset();
    idle_inputs();
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs(k) !== RST_V) begin
        failures++;
        $display("FAIL midreset k=%0d got=%h exp=%h", k, obs(k), RST_V);
      end
    end
    mem[7] = ~mem[7];
    mem[9] = ~mem[9];
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if ({q_valid[k], t_valid[k]} !== 2'b00 || obs(k) !== expv(k)) begin
          failures++;
          $display("FAIL midreset_quiet k=%0d i=%0d got=%h exp=%h",
                   k, i, obs(k), expv(k));
        end
      end
    end
  endtask

  task automatic test_random();
    int prev;
    bit qv1;
    bit tv1;
    bit qv0;
    bit tv0;
    prev = -1;
    qv0 = 1'b0;
    tv0 = 1'b0;
    qv1 = 1'b0;
    tv1 = 1'b0;
    do_reset();
    q_addr[1] = 10'($urandom_range(0, 1023));
    t_addr[1] = 10'($urandom_range(0, 1023));
    q_req[1]  = 1'b1;
    t_req[1]  = 1'b1;
    for (int i = 0; i < 110; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs(k) !== expv(k)) begin
          failures++;
          $display("FAIL random k=%0d i=%0d got=%h exp=%h",
                   k, i, obs(k), expv(k));
        end
        checks++;
        if ((q_valid[k] & t_valid[k]) !== 1'b0) begin
          failures++;
          $display("FAIL coincide k=%0d i=%0d got=1 exp=0", k, i);
        end
      end
      if (q_valid[1] === 1'b1 || t_valid[1] === 1'b1) begin
        checks++;
        if (prev == (q_valid[1] ? 0 : 1)) begin
          failures++;
          $display("FAIL alternate i=%0d got=%0d twice", i, prev);
        end
        prev = q_valid[1] ? 0 : 1;
      end
      qv1 = e_qv[1];
      tv1 = e_tv[1];
      qv0 = e_qv[0];
      tv0 = e_tv[0];
      tick();
      if (qv1) q_addr[1] = 10'($urandom_range(0, 1023));
      if (tv1) t_addr[1] = 10'($urandom_range(0, 1023));
      if (!q_req[0] || qv0) begin
        q_req[0] = 1'($urandom_range(0, 1));
        if (!q_req[0] || !qv0) q_addr[0] = 10'($urandom_range(0, 1023));
      end
      if (!t_req[0] || tv0) begin
        t_req[0] = 1'($urandom_range(0, 1));
        if (!t_req[0] || !tv0) t_addr[0] = 10'($urandom_range(0, 1023));
      end
      if (i >= 100) idle_inputs();
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 30'($urandom);
    test_reset();
    test_single();
    test_tie();
    test_wrap();
    test_drop();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
